// File: rtl/poly_arith_pkg.sv
// Shared modular-arithmetic definitions for the q = 3329 coefficient ring.
// Imported by base_case_mac and its testbench.
package poly_arith_pkg;

    typedef logic [11:0] coeff_t;

    localparam int unsigned Q = 3329;

    // Both operands must already be canonical; the result is canonical.
    function automatic coeff_t mod_add(input coeff_t a, input coeff_t b);
        logic [12:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 13'(Q)) begin
            sum = sum - 13'(Q);
        end
        return sum[11:0];
    endfunction

endpackage

// File: rtl/bcm_out_fifo.sv
// Result buffer for base_case_mac: synchronous FIFO, WIDTH x DEPTH, any DEPTH >= 2.
// rdata reads as zero while empty so the block outputs stay at zero with nothing to show.
module bcm_out_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full, do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign valid   = (count_q != '0);
    assign do_pop  = pop && valid;
    // A push into a full buffer is fine when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = valid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/base_case_mac.sv
// Multi-lane base-case multiply-accumulate mod 3329 with grouped accumulation and a credited
// output buffer. Define BASE_CASE_MAC_ERR_EN to add the sticky protocol-error flag err_o.
module base_case_mac
    import poly_arith_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    first_i,
    input  logic                    last_i,
    input  coeff_t [NUM_LANES-1:0]  a0_i,
    input  coeff_t [NUM_LANES-1:0]  a1_i,
    input  coeff_t [NUM_LANES-1:0]  b0_i,
    input  coeff_t [NUM_LANES-1:0]  b1_i,
    input  coeff_t [NUM_LANES-1:0]  zeta_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output coeff_t [NUM_LANES-1:0]  c0_o,
    output coeff_t [NUM_LANES-1:0]  c1_o
`ifdef BASE_CASE_MAC_ERR_EN
    ,
    output logic                    err_o
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FW = 2 * NUM_LANES * $bits(coeff_t);

    logic            live_q;
    logic [CW-1:0]   credits_q, credits_d;
    logic            accept, pop;
    logic            group_open_q, group_open_d, eff_first;
    logic [LATENCY-1:0] pv_q, pf_q, pl_q;
    logic            push_q;
    logic [FW-1:0]   fifo_rdata;

    coeff_t [NUM_LANES-1:0] s0_a0_q, s0_a1_q, s0_b0_q, s0_b1_q, s0_zeta_q;
    coeff_t [NUM_LANES-1:0] prod0, prod1;
    coeff_t [NUM_LANES-1:0] pp0_q [1:LATENCY-1];
    coeff_t [NUM_LANES-1:0] pp1_q [1:LATENCY-1];
    coeff_t [NUM_LANES-1:0] acc0_q, acc1_q, acc0_d, acc1_d;

    // credits_q counts every accepted last beat not yet popped: in flight plus buffered.
    assign ready_o   = live_q && (credits_q < CW'(FIFO_DEPTH));
    assign accept    = valid_i && ready_o;
    assign pop       = valid_o && ready_i;
    assign eff_first = first_i || !group_open_q;

    always_comb begin
        credits_d    = credits_q;
        group_open_d = group_open_q;
        if (accept && last_i) begin
            credits_d = credits_d + 1'b1;
        end
        if (pop) begin
            credits_d = credits_d - 1'b1;
        end
        if (accept) begin
            group_open_d = !last_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q       <= 1'b0;
            credits_q    <= '0;
            group_open_q <= 1'b0;
            pv_q         <= '0;
            pf_q         <= '0;
            pl_q         <= '0;
            push_q       <= 1'b0;
        end else begin
            live_q       <= 1'b1;
            credits_q    <= credits_d;
            group_open_q <= group_open_d;
            pv_q         <= {pv_q[LATENCY-2:0], accept};
            pf_q         <= {pf_q[LATENCY-2:0], eff_first};
            pl_q         <= {pl_q[LATENCY-2:0], last_i};
            push_q       <= pv_q[LATENCY-1] && pl_q[LATENCY-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_a0_q   <= '0;
            s0_a1_q   <= '0;
            s0_b0_q   <= '0;
            s0_b1_q   <= '0;
            s0_zeta_q <= '0;
        end else if (accept) begin
            s0_a0_q   <= a0_i;
            s0_a1_q   <= a1_i;
            s0_b0_q   <= b0_i;
            s0_b1_q   <= b1_i;
            s0_zeta_q <= zeta_i;
        end
    end

    // Full 24-bit products keep the result exact for non-canonical 12-bit operands.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [23:0] m00, m11, m01, m10, m11z;
        logic [11:0] m11_r;
        logic [24:0] sum0, sum1;

        assign m00        = 24'(s0_a0_q[l]) * 24'(s0_b0_q[l]);
        assign m11        = 24'(s0_a1_q[l]) * 24'(s0_b1_q[l]);
        assign m01        = 24'(s0_a0_q[l]) * 24'(s0_b1_q[l]);
        assign m10        = 24'(s0_a1_q[l]) * 24'(s0_b0_q[l]);
        assign m11_r      = 12'(m11 % 24'(Q));
        assign m11z       = 24'(m11_r) * 24'(s0_zeta_q[l]);
        assign sum0       = 25'(m00) + 25'(m11z);
        assign sum1       = 25'(m01) + 25'(m10);
        assign prod0[l]   = 12'(sum0 % 25'(Q));
        assign prod1[l]   = 12'(sum1 % 25'(Q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < LATENCY; k++) begin
                pp0_q[k] <= '0;
                pp1_q[k] <= '0;
            end
        end else begin
            pp0_q[1] <= prod0;
            pp1_q[1] <= prod1;
            for (int k = 2; k < LATENCY; k++) begin
                pp0_q[k] <= pp0_q[k-1];
                pp1_q[k] <= pp1_q[k-1];
            end
        end
    end

    always_comb begin
        acc0_d = acc0_q;
        acc1_d = acc1_q;
        if (pv_q[LATENCY-1]) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (pf_q[LATENCY-1]) begin
                    acc0_d[l] = pp0_q[LATENCY-1][l];
                    acc1_d[l] = pp1_q[LATENCY-1][l];
                end else begin
                    acc0_d[l] = mod_add(acc0_q[l], pp0_q[LATENCY-1][l]);
                    acc1_d[l] = mod_add(acc1_q[l], pp1_q[LATENCY-1][l]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc0_q <= '0;
            acc1_q <= '0;
        end else begin
            acc0_q <= acc0_d;
            acc1_q <= acc1_d;
        end
    end

    // push_q trails the final accumulate by one edge, so the buffer captures the settled sum.
    bcm_out_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .wdata ({acc1_q, acc0_q}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .valid (valid_o)
    );

    assign {c1_o, c0_o} = fifo_rdata;

`ifdef BASE_CASE_MAC_ERR_EN
    logic err_q;
    logic violation;

    assign violation = accept && ((!first_i && !group_open_q) || (first_i && group_open_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (violation) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_base_case_mac.sv
// Directed bench for base_case_mac with an arithmetic reference model and per-cycle compare.
// Define BASE_CASE_MAC_ERR_EN to also check err_o.
module tb_base_case_mac;
    import poly_arith_pkg::*;

    localparam int NL    = 2;
    localparam int DEPTH = 8;
    localparam int QM    = 3329;

    typedef logic [2*NL*12-1:0] res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_i, ready_o, first_i, last_i, valid_o, ready_i;
    coeff_t [NL-1:0] a0_i, a1_i, b0_i, b1_i, zeta_i, c0_o, c1_o;
`ifdef BASE_CASE_MAC_ERR_EN
    logic err_o;
`endif

    always #5 clk = ~clk;

    base_case_mac u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .first_i (first_i),
        .last_i  (last_i),
        .a0_i    (a0_i),
        .a1_i    (a1_i),
        .b0_i    (b0_i),
        .b1_i    (b1_i),
        .zeta_i  (zeta_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .c0_o    (c0_o),
        .c1_o    (c1_o)
`ifdef BASE_CASE_MAC_ERR_EN
        ,
        .err_o   (err_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results in acceptance order, group state, and credit bookkeeping.
    res_t exp_q[$];
    int   macc0 [NL];
    int   macc1 [NL];
    bit   open_m;
    bit   err_exp;
    int   outstanding;
    int   pops;
    logic live_q;

    always @(posedge clk) live_q <= rst_n;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset ready_o", ready_o, 0);
            chk("reset valid_o", valid_o, 0);
            chk("reset c0_o", c0_o, 0);
            chk("reset c1_o", c1_o, 0);
`ifdef BASE_CASE_MAC_ERR_EN
            chk("reset err_o", err_o, 0);
`endif
            exp_q.delete();
            open_m      = 0;
            err_exp     = 0;
            outstanding = 0;
            for (int l = 0; l < NL; l++) begin
                macc0[l] = 0;
                macc1[l] = 0;
            end
        end else begin
            chk("ready_o", ready_o, (live_q === 1'b1 && outstanding < DEPTH) ? 1 : 0);
`ifdef BASE_CASE_MAC_ERR_EN
            chk("err_o", err_o, err_exp);
`endif
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("valid_o with nothing expected", 1, 0);
                end else begin
                    chk("c0_o", c0_o, exp_q[0][NL*12-1:0]);
                    chk("c1_o", c1_o, exp_q[0][2*NL*12-1:NL*12]);
                    if (ready_i) begin
                        void'(exp_q.pop_front());
                        outstanding--;
                        pops++;
                    end
                end
            end
            if (valid_i && ready_o) begin
                bit   eff;
                res_t r;
                longint p0, p1;
                eff = first_i || !open_m;
                if (first_i == open_m) err_exp = 1;
                for (int l = 0; l < NL; l++) begin
                    p0 = (longint'(a0_i[l]) * b0_i[l] + longint'(a1_i[l]) * b1_i[l] * zeta_i[l]) % QM;
                    p1 = (longint'(a0_i[l]) * b1_i[l] + longint'(a1_i[l]) * b0_i[l]) % QM;
                    macc0[l] = eff ? int'(p0) : int'((macc0[l] + p0) % QM);
                    macc1[l] = eff ? int'(p1) : int'((macc1[l] + p1) % QM);
                    r[l*12 +: 12]         = 12'(macc0[l]);
                    r[NL*12 + l*12 +: 12] = 12'(macc1[l]);
                end
                open_m = !last_i;
                if (last_i) begin
                    exp_q.push_back(r);
                    outstanding++;
                end
            end
        end
    end

    task automatic idle();
        valid_i = 0;
        first_i = 0;
        last_i  = 0;
        a0_i = '0; a1_i = '0; b0_i = '0; b1_i = '0; zeta_i = '0;
    endtask

    task automatic set_lane(input int l, input int xa0, input int xa1, input int xb0,
                            input int xb1, input int xz);
        a0_i[l] = 12'(xa0); a1_i[l] = 12'(xa1);
        b0_i[l] = 12'(xb0); b1_i[l] = 12'(xb1);
        zeta_i[l] = 12'(xz);
    endtask

    // Offers one beat and returns at #1 after the accepting edge.
    task automatic send(input bit f, input bit l);
        bit ok = 0;
        valid_i = 1; first_i = f; last_i = l;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ready_o) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        valid_i = 0; first_i = 0; last_i = 0;
        if (!ok) chk("send accepted", 0, 1);
    endtask

    task automatic wait_valid(output int n);
        for (n = 0; n < 40; n++) begin
            if (valid_o) break;
            @(posedge clk); #1;
        end
        if (n >= 40) chk("valid_o timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        int n, p_before, vcount;
        ready_i = 1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("in reset ready_o", ready_o, 0);
        chk("in reset valid_o", valid_o, 0);
        rst_n = 1;
        chk("ready_o before first edge", ready_o, 0);
        @(posedge clk); #1;
        chk("ready_o after first edge", ready_o, 1);

        // Plain multiply and LATENCY+1 to valid_o.
        set_lane(0, 1, 0, 1, 0, 100);
        send(1, 1);
        wait_valid(n);
        chk("t1 latency", n, 5);
        chk("t1 c0", c0_o[0], 1);
        chk("t1 c1", c1_o[0], 0);
        idle();
        repeat (3) @(posedge clk); #1;

        // zeta path on lane 0, independent lane 1.
        set_lane(0, 0, 1, 0, 1, 50);
        set_lane(1, 2, 0, 3, 0, 0);
        send(1, 1);
        wait_valid(n);
        chk("t2 lane0 c0", c0_o[0], 50);
        chk("t2 lane0 c1", c1_o[0], 0);
        chk("t2 lane1 c0", c0_o[1], 6);
        chk("t2 lane1 c1", c1_o[1], 0);
        idle();
        repeat (3) @(posedge clk); #1;

        // Three-beat group of (-1)*(-1) terms.
        p_before = pops;
        set_lane(0, 3328, 0, 3328, 0, 0);
        send(1, 0);
        send(0, 0);
        send(0, 1);
        wait_valid(n);
        chk("t3 c0", c0_o[0], 3);
        chk("t3 c1", c1_o[0], 0);
        repeat (10) @(posedge clk); #1;
        chk("t3 output count", pops - p_before, 1);

        // A new first beat drops the open partial sum.
        set_lane(0, 2, 0, 2, 0, 0);
        send(1, 0);
        set_lane(0, 1, 0, 7, 0, 0);
        send(1, 1);
        wait_valid(n);
        chk("t3b c0", c0_o[0], 7);
        idle();
        repeat (3) @(posedge clk); #1;

        // Back-pressure: eight credits, then twelve results in order.
        ready_i = 0;
        p_before = pops;
        for (int i = 0; i < 12; i++) begin
            set_lane(0, i + 1, i, i + 2, 3, 7 + i);
            set_lane(1, 100 * i, 4095, 4095, 4095, 4095);
            if (i == 8) begin
                valid_i = 1; first_i = 1; last_i = 1;
                vcount = 0;
                repeat (6) begin
                    @(negedge clk);
                    if (ready_o) vcount++;
                end
                chk("t4 ready_o low when full", vcount, 0);
                chk("t4 nothing popped while stalled", pops - p_before, 0);
                @(posedge clk); #1;
                ready_i = 1;
            end
            send(1, 1);
        end
        idle();
        repeat (30) @(posedge clk); #1;
        chk("t4 results drained", pops - p_before, 12);

        // Reset in mid-group discards everything.
        set_lane(0, 1, 1, 1, 1, 1);
        send(1, 0);
        send(0, 0);
        do_reset();
        idle();
        vcount = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (valid_o) vcount++;
        end
        chk("t5 no output after reset", vcount, 0);
        set_lane(0, 1, 0, 5, 0, 0);
        send(1, 1);
        wait_valid(n);
        chk("t5 c0", c0_o[0], 5);
        idle();
        repeat (3) @(posedge clk); #1;

`ifdef BASE_CASE_MAC_ERR_EN
        do_reset();
        @(posedge clk); #1;
        chk("t6 err_o clear", err_o, 0);
        set_lane(0, 2, 0, 3, 0, 0);
        send(0, 1);
        wait_valid(n);
        chk("t6 err_o set", err_o, 1);
        chk("t6 c0", c0_o[0], 6);
        idle();
        repeat (6) @(posedge clk); #1;
        chk("t6 err_o sticky", err_o, 1);
        do_reset();
        chk("t6 err_o after reset", err_o, 0);
`endif

        repeat (5) @(posedge clk); #1;
        chk("final queue empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/base_case_mac.md
BASE_CASE_MAC -- requirements
Module: base_case_mac

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2: independent base-case lanes processed per beat.
REQ-002 SHALL have parameter LATENCY, default 4: multiply/reduce pipeline depth in cycles, with a minimum of 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: output buffer entries, with a minimum of LATENCY+1.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 valid_i  in  1  input beat valid.
REQ-007 ready_o  out  1  block can accept a beat.
REQ-008 first_i  in  1  beat opens an accumulation group.
REQ-009 last_i  in  1  beat closes the group and emits the result.
REQ-010 a0_i, a1_i, b0_i, b1_i, zeta_i  in  NUM_LANES x coeff_t  per-lane operands.
REQ-011 valid_o  out  1  output result valid.
REQ-012 ready_i  in  1  downstream can accept the result.
REQ-013 c0_o, c1_o  out  NUM_LANES x coeff_t  per-lane results.
REQ-014 err_o  out  1  sticky protocol error flag; present only under the configuration macro.

Function
REQ-015 Each lane SHALL compute the product p0 = (a0*b0 + a1*b1*zeta) mod Q and p1 = (a0*b1 + a1*b0) mod Q, with Q = 3329.
REQ-016 Products SHALL be exact for any 12-bit operand value, and every output SHALL be canonical in [0, Q-1].
REQ-017 A beat SHALL be accepted on a rising edge where valid_i && ready_o; operands are ignored otherwise.
REQ-018 The accumulator SHALL be updated LATENCY cycles after acceptance: acc = p on a first_i beat, otherwise acc = (acc + p) mod Q.
- The accumulator is one register per lane per output.
REQ-019 Only last_i beats SHALL push acc into the output FIFO; first_i=last_i=1 is a plain multiply.
REQ-020 With the FIFO empty and ready_i=1, valid_o SHALL rise LATENCY+1 cycles after the accepting edge.
REQ-021 Output SHALL follow valid/ready semantics: c0_o/c1_o are held stable while valid_o && !ready_i, and a pop occurs on valid_o && ready_i.
REQ-022 Flow control SHALL be credit-based: ready_o = (fifo_count + in_flight_last_beats) < FIFO_DEPTH.
- No result is ever dropped.
- ready_o does not depend combinationally on valid_i.
REQ-023 A simultaneous push and pop on a full FIFO SHALL be legal and SHALL leave the count unchanged.
REQ-024 Results SHALL leave the block in acceptance order, with no reordering between lanes or groups.
REQ-025 A non-first beat with no open group SHALL be treated as first_i=1.
REQ-026 A first_i beat while a group is open SHALL discard the open group's partial sum.
REQ-027 Back-to-back beats every cycle SHALL sustain throughput 1 beat/cycle while credits remain.

Reset
REQ-028 While rst_n=0 the following SHALL be forced:
- ready_o=0, valid_o=0, c0_o=c1_o=0, err_o=0;
- FIFO count=0, pipeline valid bits cleared, group-open flag cleared, accumulators=0.
REQ-029 Reset asserted mid-group or mid-drain SHALL discard all in-flight and buffered data.
REQ-030 ready_o SHALL assert on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro BASE_CASE_MAC_ERR_EN: when defined, port err_o exists and is set sticky (cleared only by reset) on either protocol violation:
- a non-first beat with no open group (REQ-025);
- a first_i beat while a group is open (REQ-026).
REQ-032 When BASE_CASE_MAC_ERR_EN is undefined, err_o and its logic SHALL be absent, and data behaviour SHALL be identical.

Structure
REQ-033 poly_arith_pkg SHALL hold coeff_t (12-bit), the constant Q=3329, and a canonical mod-Q add function; the block SHALL import it.
REQ-034 The output buffer SHALL be a separate sub-module, bcm_out_fifo, parameterised by width and depth.
REQ-035 Lane arithmetic SHALL be a generate loop inside base_case_mac.

Verification
REQ-036 Bench SHALL cover each of the following with default parameters:
- Single beat, first=last=1, a=(1,0), b=(1,0), zeta=100 -> c0=1, c1=0, valid_o exactly 5 cycles after acceptance.
- Single beat, a=(0,1), b=(0,1), zeta=50 -> c0=50, c1=0; lane 1 with a=(2,0), b=(3,0) concurrently -> c0=6, c1=0.
- Three-beat group (first, mid, last), each beat a=(3328,0), b=(3328,0) -> exactly one output, c0=3, c1=0.
- ready_i=0 while 12 single-beat vectors are offered -> ready_o falls after 8 acceptances; release ready_i -> 12 results in order, none lost.
- rst_n pulsed low after the 2nd beat of a 3-beat group -> valid_o stays 0; the following group first=last with a=(1,0), b=(5,0) -> c0=5.
- With BASE_CASE_MAC_ERR_EN defined, a first_i=0 beat right after reset -> err_o=1 and held until reset; result computed as if first_i=1.
